// File: rtl/mips32_pkg.sv
// Shared MIPS32 constants: datapath width, register address width and
// the named architectural registers used by the pipeline and benches.
package mips32_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_T0   = 8;
  localparam int REG_T1   = 9;
  localparam int REG_T2   = 10;
endpackage

// File: rtl/regfile_mp_sb_if.sv
// Register-file bus: NRD flat-packed read ports, one write port, the
// reservation port, busy count and the debug read port.
interface regfile_mp_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  rsv_en;
  logic [ADDR_W-1:0]     rsv_addr;
  logic [ADDR_W:0]       busy_cnt;
  logic [ADDR_W-1:0]     dbg_addr;
  logic [DATA_W-1:0]     dbg_data;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, dbg_addr,
    input  rd_data, rd_busy, busy_cnt, dbg_data
  );
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, dbg_addr,
    output rd_data, rd_busy, busy_cnt, dbg_data
  );
endinterface

// File: rtl/regfile_busy_tracker.sv
// Per-register busy scoreboard. A reservation sets the bit, a write-back
// releases it; a same-cycle reserve of the same register wins so the new
// owner keeps it. busy_cnt follows the vector incrementally.
module regfile_busy_tracker
  import mips32_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr_en,
  input  logic [ADDR_W-1:0]      i_wr_addr,
  input  logic                   i_rsv_en,
  input  logic [ADDR_W-1:0]      i_rsv_addr,
  output logic [2**ADDR_W-1:0]   o_busy,
  output logic [2**ADDR_W-1:0]   o_rel,
  output logic [ADDR_W:0]        o_cnt
);
  localparam int DEPTH = 2**ADDR_W;

  logic             w_wr_ok, w_rsv_ok, w_set_new, w_clr;
  logic [DEPTH-1:0] w_set, w_rel;
  logic [DEPTH-1:0] r_busy;
  logic [ADDR_W:0]  r_cnt;

  // register 0 can never be reserved or released when it is hard-wired
  assign w_wr_ok  = i_wr_en  && !(ZERO_REG != 0 && i_wr_addr  == ADDR_W'(REG_ZERO));
  assign w_rsv_ok = i_rsv_en && !(ZERO_REG != 0 && i_rsv_addr == ADDR_W'(REG_ZERO));

  // one-hot set/release decode; reserve masks release on the same register
  always_comb begin
    w_set = '0;
    w_rel = '0;
    if (w_rsv_ok) w_set[i_rsv_addr] = 1'b1;
    if (w_wr_ok)  w_rel[i_wr_addr]  = 1'b1;
    w_rel = w_rel & ~w_set;
  end

  assign w_set_new = w_rsv_ok && !r_busy[i_rsv_addr];
  assign w_clr     = |(w_rel & r_busy);

  // busy vector and its population count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= (r_busy & ~w_rel) | w_set;
      r_cnt  <= r_cnt + (ADDR_W+1)'(w_set_new) - (ADDR_W+1)'(w_clr);
    end
  end

  assign o_busy = r_busy;
  assign o_rel  = w_rel;
  assign o_cnt  = r_cnt;
endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read, single-write register file with optional write bypass,
// optional hard-wired zero register, busy scoreboard and debug port.
module regfile_mp_sb
  import mips32_pkg::*;
#(
  parameter int DATA_W   = mips32_pkg::DATA_W,
  parameter int ADDR_W   = mips32_pkg::REG_ADDR_W,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  regfile_mp_sb_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_busy, w_rel;
  logic              w_wr_ok;

  assign w_wr_ok = bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == ADDR_W'(REG_ZERO));

  regfile_busy_tracker #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_busy (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (bus.wr_en),
    .i_wr_addr  (bus.wr_addr),
    .i_rsv_en   (bus.rsv_en),
    .i_rsv_addr (bus.rsv_addr),
    .o_busy     (w_busy),
    .o_rel      (w_rel),
    .o_cnt      (bus.busy_cnt)
  );

  // storage array; register 0 stays 0 when hard-wired
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else if (w_wr_ok) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // read ports: zero reg, then bypass, then array; all held at 0 in reset
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_zero, w_byp;
    assign w_ra   = bus.rd_addr[g*ADDR_W +: ADDR_W];
    assign w_zero = (ZERO_REG != 0) && (w_ra == ADDR_W'(REG_ZERO));
    assign w_byp  = (BYPASS != 0) && bus.wr_en && (w_ra == bus.wr_addr);
    assign bus.rd_data[g*DATA_W +: DATA_W] = (!rst || w_zero) ? '0 :
                                             w_byp ? bus.wr_data : r_mem[w_ra];
    // a releasing write hides the hazard only when its data is bypassed
    assign bus.rd_busy[g] = w_busy[w_ra] && !((BYPASS != 0) && w_rel[w_ra]);
  end

  assign bus.dbg_data = r_mem[bus.dbg_addr];
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed vector bench for regfile_mp_sb (default parameters: NRD=2,
// BYPASS=1, ZERO_REG=1). Combinational outputs are checked before the
// rising edge, busy_cnt just after it.
module tb_regfile_mp_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) bus ();

  regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rsv_en;
    logic [AW-1:0] rsv_addr;
    logic [AW-1:0] ra0, ra1, dbg;
    logic [DW-1:0] e_rd0, e_rd1, e_dbg;
    logic          e_bz0, e_bz1;
    logic [AW:0]   e_cnt;
  } vec_t;

  localparam int NV = 21;
  vec_t tv [NV];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(logic we, int wa, logic [DW-1:0] wd, logic re, int rsa,
                              int a0, int a1, int da, logic [DW-1:0] r0, logic [DW-1:0] r1,
                              logic b0, logic b1, logic [DW-1:0] dd, int cnt);
    vec_t v;
    v.wr_en = we; v.wr_addr = AW'(wa); v.wr_data = wd;
    v.rsv_en = re; v.rsv_addr = AW'(rsa);
    v.ra0 = AW'(a0); v.ra1 = AW'(a1); v.dbg = AW'(da);
    v.e_rd0 = r0; v.e_rd1 = r1; v.e_bz0 = b0; v.e_bz1 = b1; v.e_dbg = dd;
    v.e_cnt = (AW+1)'(cnt);
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [DW-1:0] act, logic [DW-1:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.wr_en = v.wr_en; bus.wr_addr = v.wr_addr; bus.wr_data = v.wr_data;
    bus.rsv_en = v.rsv_en; bus.rsv_addr = v.rsv_addr;
    bus.rd_addr = {v.ra1, v.ra0}; bus.dbg_addr = v.dbg;
  endtask

  task automatic apply(vec_t v, int idx);
    @(negedge clk);
    drive(v);
    #1;
    n_vec++;
    chk("rd_data0", idx, bus.rd_data[DW-1:0], v.e_rd0);
    chk("rd_data1", idx, bus.rd_data[2*DW-1:DW], v.e_rd1);
    chk("rd_busy0", idx, DW'(bus.rd_busy[0]), DW'(v.e_bz0));
    chk("rd_busy1", idx, DW'(bus.rd_busy[1]), DW'(v.e_bz1));
    chk("dbg_data", idx, bus.dbg_data, v.e_dbg);
    @(posedge clk);
    #1;
    chk("busy_cnt", idx, DW'(bus.busy_cnt), DW'(v.e_cnt));
  endtask

  vec_t idle;

  initial begin
    //          we wa  wd            re ra  a0 a1 da  rd0           rd1           b0 b1 dbg           cnt
    tv[0]  = mk(0, 0,  0,            0, 0,  0, 0, 0,  0,            0,            0, 0, 0,            0);
    tv[1]  = mk(1, 8,  2,            0, 0,  8, 9, 8,  2,            0,            0, 0, 0,            0);
    tv[2]  = mk(1, 9,  3,            0, 0,  8, 9, 8,  2,            3,            0, 0, 2,            0);
    tv[3]  = mk(1, 10, 5,            0, 0, 10, 9, 9,  5,            3,            0, 0, 3,            0);
    tv[4]  = mk(0, 0,  0,            0, 0, 10, 8, 10, 5,            2,            0, 0, 5,            0);
    tv[5]  = mk(1, 9,  32'hDEADBEEF, 0, 0,  9, 10, 9, 32'hDEADBEEF, 5,            0, 0, 3,            0);
    tv[6]  = mk(0, 0,  0,            0, 0,  9, 10, 9, 32'hDEADBEEF, 5,            0, 0, 32'hDEADBEEF, 0);
    tv[7]  = mk(1, 0,  32'h1234,     1, 0,  0, 0, 0,  0,            0,            0, 0, 0,            0);
    tv[8]  = mk(0, 0,  0,            0, 0,  0, 0, 0,  0,            0,            0, 0, 0,            0);
    tv[9]  = mk(0, 0,  0,            1, 8,  8, 9, 8,  2,            32'hDEADBEEF, 0, 0, 2,            1);
    tv[10] = mk(0, 0,  0,            0, 0,  8, 8, 8,  2,            2,            1, 1, 2,            1);
    tv[11] = mk(0, 0,  0,            0, 0,  8, 8, 8,  2,            2,            1, 1, 2,            1);
    tv[12] = mk(1, 8,  7,            0, 0,  8, 9, 8,  7,            32'hDEADBEEF, 0, 0, 2,            0);
    tv[13] = mk(0, 0,  0,            0, 0,  8, 9, 8,  7,            32'hDEADBEEF, 0, 0, 7,            0);
    tv[14] = mk(0, 0,  0,            1, 8,  8, 9, 8,  7,            32'hDEADBEEF, 0, 0, 7,            1);
    tv[15] = mk(1, 8,  9,            1, 8,  8, 9, 8,  9,            32'hDEADBEEF, 1, 0, 7,            1);
    tv[16] = mk(0, 0,  0,            0, 0,  8, 9, 8,  9,            32'hDEADBEEF, 1, 0, 9,            1);
    tv[17] = mk(1, 8,  11,           1, 10, 8, 10, 10, 11,          5,            0, 0, 5,            1);
    tv[18] = mk(0, 0,  0,            0, 0,  8, 10, 8, 11,           5,            0, 1, 11,           1);
    tv[19] = mk(0, 0,  0,            1, 10, 8, 10, 8, 11,           5,            0, 1, 11,           1);
    tv[20] = mk(1, 9,  4,            0, 0,  8, 9, 9,  11,           4,            0, 0, 32'hDEADBEEF, 1);

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) apply(tv[i], i);

    // release r10, then reserve t0/t1/t2 back to back
    apply(mk(1, 10, 6, 0, 0, 10, 8, 10, 6, 11, 0, 0, 5, 0), 100);
    apply(mk(0, 0, 0, 1, 8,  8, 9, 8, 11, 4, 0, 0, 11, 1), 101);
    apply(mk(0, 0, 0, 1, 9,  8, 9, 9, 11, 4, 1, 0, 4, 2), 102);
    apply(mk(0, 0, 0, 1, 10, 8, 10, 10, 11, 6, 1, 0, 6, 3), 103);

    // asynchronous reset mid-cycle: everything must drop without a clock edge
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 8, 10, 8, 0, 0, 0, 0, 0, 0));
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    chk("rst_rd_data0", 200, bus.rd_data[DW-1:0], 0);
    chk("rst_rd_data1", 200, bus.rd_data[2*DW-1:DW], 0);
    chk("rst_rd_busy",  200, DW'(bus.rd_busy), 0);
    chk("rst_busy_cnt", 200, DW'(bus.busy_cnt), 0);
    chk("rst_dbg_data", 200, bus.dbg_data, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    apply(mk(0, 0, 0, 0, 0, 8, 10, 8, 0, 0, 0, 0, 0, 0), 201);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
